// File: rtl/led_arbiter.sv
// Round-robin arbiter sharing the 6-LED bank and blink pin among NREQ requesters,
// with a minimum ownership time counted in prescaled ticks so each pattern stays visible.
module led_arbiter #(
   parameter int NREQ       = 4,
   parameter int TICK_DIV   = 2**24,
   parameter int HOLD_TICKS = 8
) (
   input  logic                clk50,
   input  logic                rst,
   input  logic [NREQ-1:0]     req,
   input  logic [6*NREQ-1:0]   req_leds,
   input  logic [NREQ-1:0]     req_blink,
   output logic [NREQ-1:0]     gnt,
   output logic [5:0]          leds,
   output logic                blink,
   output logic                busy
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int PW = $clog2(TICK_DIV);
   localparam int HW = $clog2(HOLD_TICKS + 1);
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS);
   localparam logic [IW-1:0] LAST_INIT = IW'(NREQ - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_OWN    = 2'd1,
      ST_SWITCH = 2'd2
   } state_t;

   state_t          state;
   logic [IW-1:0]   owner;
   logic [IW-1:0]   last;
   logic [PW-1:0]   presc;
   logic [HW-1:0]   hold_cnt;
   logic [IW-1:0]   winner;
   logic            tick;
   logic            expired;
   logic [NREQ-1:0] others;

   function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
      logic [NREQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   function automatic logic [5:0] slice_of(input logic [6*NREQ-1:0] v, input logic [IW-1:0] idx);
      return v[int'(idx)*6 +: 6];
   endfunction

   assign tick    = (presc == PRESC_MAX);
   assign expired = (hold_cnt == HOLD_MAX);
   assign others  = req & ~onehot(owner);

   // Scan downward so the nearest set bit after last is the final write.
   always_comb begin
      int raw;
      int idx;
      winner = '0;
      for (int i = NREQ; i >= 1; i--) begin
         raw    = int'(last) + i;
         idx    = (raw >= NREQ) ? (raw - NREQ) : raw;
         winner = req[idx] ? IW'(idx) : winner;
      end
   end

   // Prescaler, hold timer and arbitration state machine with registered outputs.
   always_ff @(posedge clk50 or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         owner    <= '0;
         last     <= LAST_INIT;
         presc    <= '0;
         hold_cnt <= '0;
         gnt      <= '0;
         leds     <= 6'h00;
         blink    <= 1'b0;
         busy     <= 1'b0;
      end else begin
         presc <= tick ? '0 : presc + 1'b1;
         if (tick && !expired) begin
            hold_cnt <= hold_cnt + 1'b1;
         end else begin
            hold_cnt <= hold_cnt;
         end

         case (state)
            ST_IDLE: begin
               if (|req) begin
                  owner    <= winner;
                  gnt      <= onehot(winner);
                  leds     <= slice_of(req_leds, winner);
                  blink    <= req_blink[winner];
                  busy     <= 1'b1;
                  hold_cnt <= '0;
                  state    <= ST_OWN;
               end else begin
                  gnt   <= '0;
                  leds  <= 6'h00;
                  blink <= 1'b0;
                  busy  <= 1'b0;
               end
            end
            ST_OWN: begin
               // A release always wins; preemption needs expiry plus a competitor.
               if (!req[owner] || (expired && (|others))) begin
                  gnt   <= '0;
                  leds  <= 6'h00;
                  blink <= 1'b0;
                  busy  <= 1'b1;
                  state <= ST_SWITCH;
               end else begin
                  leds  <= slice_of(req_leds, owner);
                  blink <= req_blink[owner];
                  busy  <= 1'b1;
               end
            end
            ST_SWITCH: begin
               last  <= owner;
               gnt   <= '0;
               leds  <= 6'h00;
               blink <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               gnt   <= '0;
               leds  <= 6'h00;
               blink <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
